// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, sync byte and err codes for uart_frame_ctrl (S_CHK only with UART_FRAME_CHECKSUM_EN)
package uart_pkg;
`ifdef UART_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_OP, S_ADDR, S_LEN, S_PAYLOAD, S_ISSUE, S_CHK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_OP, S_ADDR, S_LEN, S_PAYLOAD, S_ISSUE} state_t;
`endif
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: 24-bit inter-byte idle counter, tc high on the cycle the count reaches LIMIT
module uart_gap_timer #(
  parameter int LIMIT = 2840
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);
  logic [23:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : cnt_q + 24'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == 24'(LIMIT - 1);
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: A5-synced command frame parser with gap timeout, overrun drop and optional checksum (UART_FRAME_CHECKSUM_EN)
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY  = 66_000_000,
  parameter int UART_FREQUENCY = 921_600,
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_op,
  output logic [7:0]           cmd_addr,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err,
  output logic [1:0]           err_code
);
  localparam int LIMIT = TIMEOUT_BYTES * 10 * (CLK_FREQUENCY / UART_FREQUENCY);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
  logic [7:0] sum_q, sum_d;
`else
  localparam state_t S_TAIL = S_ISSUE;
`endif
  state_t state_q, state_d;
  logic [7:0] op_q, op_d, addr_q, addr_d;
  logic [3:0] len_q, len_d, cnt_q, cnt_d;
  logic [8*MAX_LEN-1:0] pay_q, pay_d;
  logic err_q, err_d;
  logic [1:0] code_q, code_d;
  logic tc;
  uart_gap_timer #(.LIMIT(LIMIT)) u_gap (
    .clk,
    .rst_n,
    .clear(rx_valid || state_q == S_IDLE || state_q == S_ISSUE),
    .tc
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    err_d   = 1'b0;
    code_d  = code_q;
`ifdef UART_FRAME_CHECKSUM_EN
    sum_d = (rx_valid && state_q inside {S_OP, S_ADDR, S_LEN, S_PAYLOAD}) ? sum_q ^ rx_data : sum_q;
`endif
    case (state_q)
      S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d = S_OP;
        pay_d   = '0;
        cnt_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      S_OP: if (rx_valid) begin
        op_d    = rx_data;
        state_d = S_ADDR;
      end
      S_ADDR: if (rx_valid) begin
        addr_d  = rx_data;
        state_d = S_LEN;
      end
      S_LEN: if (rx_valid) begin
        len_d   = rx_data[3:0];
        state_d = rx_data == 8'd0 ? S_TAIL : rx_data > 8'(MAX_LEN) ? S_IDLE : S_PAYLOAD;
        err_d   = rx_data > 8'(MAX_LEN);
        code_d  = err_d ? ERR_LEN : code_q;
      end
      S_PAYLOAD: if (rx_valid) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (cnt_q == 4'(i)) pay_d[8*i +: 8] = rx_data;
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_d == len_q ? S_TAIL : S_PAYLOAD;
      end
`ifdef UART_FRAME_CHECKSUM_EN
      S_CHK: if (rx_valid) begin
        state_d = rx_data == sum_q ? S_ISSUE : S_IDLE;
        err_d   = rx_data != sum_q;
        code_d  = err_d ? ERR_CHK : code_q;
      end
`endif
      S_ISSUE: begin
        err_d   = rx_valid;
        code_d  = rx_valid ? ERR_OVERRUN : code_q;
        state_d = cmd_ready ? S_IDLE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rx_valid && tc && state_q != S_IDLE && state_q != S_ISSUE) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pay_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  assign cmd_valid   = state_q == S_ISSUE;
  assign cmd_op      = op_q;
  assign cmd_addr    = addr_q;
  assign cmd_len     = len_q;
  assign cmd_payload = pay_q;
  assign err         = err_q;
  assign err_code    = code_q;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed frames checked every cycle against a queue-based frame model plus literal expectations
module tb_uart_frame_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LIMIT = 4 * 10 * (66_000_000 / 921_600);
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic cmd_ready = 1'b1;
  logic cmd_valid, err;
  logic [7:0] cmd_op, cmd_addr;
  logic [3:0] cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic [1:0] err_code;
  int checks = 0;
  int errors = 0;
  logic run = 1'b0;
  logic m_valid = 1'b0, m_err = 1'b0;
  logic [1:0] m_code = '0;
  logic [7:0] m_op = '0, m_addr = '0;
  logic [3:0] m_len = '0;
  logic [8*MAX_LEN-1:0] m_pay = '0;
  logic [7:0] fr[$];
  logic [7:0] tx[$];
  int gap = 0;
  uart_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) if (run) begin
    chk("cmd_valid", 64'(cmd_valid), 64'(m_valid));
    chk("err", 64'(err), 64'(m_err));
    if (m_err) chk("err_code", 64'(err_code), 64'(m_code));
    if (m_valid) begin
      chk("cmd_op", 64'(cmd_op), 64'(m_op));
      chk("cmd_addr", 64'(cmd_addr), 64'(m_addr));
      chk("cmd_len", 64'(cmd_len), 64'(m_len));
      chk("cmd_payload", 64'(cmd_payload), 64'(m_pay));
    end
  end
  task automatic model_reset();
    m_valid = 0; m_err = 0; m_code = 0; m_op = 0; m_addr = 0; m_len = 0; m_pay = 0;
    fr.delete();
    gap = 0;
  endtask
  task automatic finish_frame();
    logic [7:0] x;
    logic bad;
    x = 0;
    bad = 0;
    if (CK == 1) begin
      for (int i = 1; i < fr.size() - 1; i++) x ^= fr[i];
      bad = x != fr[fr.size()-1];
    end
    if (bad) begin
      m_err = 1; m_code = 2;
    end else begin
      m_valid = 1; m_op = fr[1]; m_addr = fr[2]; m_len = 4'(fr[3]); m_pay = '0;
      for (int i = 0; i < int'(fr[3]); i++) m_pay[8*i +: 8] = fr[4+i];
    end
    fr.delete();
  endtask
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data = d;
    @(posedge clk);
    #1;
    rx_valid = 0;
    m_err = 0;
    if (m_valid) begin
      if (v) begin m_err = 1; m_code = 3; end
      if (cmd_ready) m_valid = 0;
    end else if (v) begin
      gap = 0;
      if (fr.size() > 0 || d == 8'hA5) fr.push_back(d);
      if (fr.size() == 4 && int'(d) > MAX_LEN) begin
        m_err = 1; m_code = 1; fr.delete();
      end else if (fr.size() >= 4 && fr.size() == 4 + int'(fr[3]) + CK) finish_frame();
    end else if (fr.size() > 0) begin
      gap++;
      if (gap == LIMIT) begin m_err = 1; m_code = 0; fr.delete(); end
    end
  endtask
  task automatic send_tx(input logic add_chk);
    logic [7:0] x;
    x = 0;
    for (int i = 1; i < tx.size(); i++) x ^= tx[i];
    if (add_chk && CK == 1) tx.push_back(x);
    foreach (tx[i]) step(1'b1, tx[i]);
  endtask
  initial begin
    int n;
    #2 rst_n = 0;
    model_reset();
    run = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_valid", 64'(cmd_valid), 64'h0);
    chk("rst_payload", 64'(cmd_payload), 64'h0);
    step(0, 0);
    tx = '{8'hA5, 8'h10, 8'h20, 8'h02, 8'hAA, 8'hBB};
    cmd_ready = 0;
    send_tx(1);
    chk("f1_valid", 64'(cmd_valid), 64'h1);
    chk("f1_op", 64'(cmd_op), 64'h10);
    chk("f1_addr", 64'(cmd_addr), 64'h20);
    chk("f1_len", 64'(cmd_len), 64'h2);
    chk("f1_payload", 64'(cmd_payload), 64'hBBAA);
    repeat (50) step(0, 0);
    step(1, 8'h55);
    chk("ovr_err", 64'(err), 64'h1);
    chk("ovr_code", 64'(err_code), 64'h3);
    chk("ovr_op_kept", 64'(cmd_op), 64'h10);
    chk("ovr_pay_kept", 64'(cmd_payload), 64'hBBAA);
    cmd_ready = 1;
    step(0, 0);
    chk("bp_fall", 64'(cmd_valid), 64'h0);
    tx = '{8'hA5, 8'h01, 8'h02, 8'h09};
    send_tx(0);
    chk("len_err", 64'(err), 64'h1);
    chk("len_code", 64'(err_code), 64'h1);
    step(0, 0);
    tx = '{8'hA5, 8'h03, 8'h04, 8'h01, 8'h77};
    send_tx(1);
    chk("f2_valid", 64'(cmd_valid), 64'h1);
    chk("f2_payload", 64'(cmd_payload), 64'h77);
    step(0, 0);
    tx = '{8'hA5, 8'h01};
    send_tx(0);
    n = 0;
    while (n < LIMIT + 100 && !err) begin
      step(0, 0);
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd2840);
    chk("timeout_code", 64'(err_code), 64'h0);
    step(0, 0);
    tx = '{8'hA5, 8'h01, 8'h02, 8'h00};
    if (CK == 1) begin
      tx.push_back(8'h00);
      send_tx(0);
      chk("chk_err", 64'(err), 64'h1);
      chk("chk_code", 64'(err_code), 64'h2);
    end else begin
      send_tx(0);
      chk("len0_valid", 64'(cmd_valid), 64'h1);
      chk("len0_len", 64'(cmd_len), 64'h0);
    end
    step(0, 0);
    step(1, 8'h00);
    step(1, 8'hFF);
    chk("junk_err", 64'(err), 64'h0);
    chk("junk_valid", 64'(cmd_valid), 64'h0);
    tx = '{8'hA5, 8'h05, 8'hA5, 8'h01, 8'hA5};
    send_tx(1);
    chk("midsync_addr", 64'(cmd_addr), 64'hA5);
    chk("midsync_payload", 64'(cmd_payload), 64'hA5);
    step(0, 0);
    tx = '{8'hA5, 8'h10, 8'h20, 8'h03, 8'hAA, 8'hBB};
    send_tx(0);
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_valid", 64'(cmd_valid), 64'h0);
    chk("mid_rst_op", 64'(cmd_op), 64'h0);
    chk("mid_rst_payload", 64'(cmd_payload), 64'h0);
    repeat (3) step(0, 0);
    rst_n = 1;
    step(0, 0);
    tx = '{8'hA5, 8'h10, 8'h20, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_tx(1);
    chk("post_rst_valid", 64'(cmd_valid), 64'h1);
    chk("post_rst_payload", 64'(cmd_payload), 64'hCCBBAA);
    repeat (3) step(0, 0);
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
